minivan_uart_tx: RTL
====================

# minivan_uart_tx

Serial transmitter for the minivan tile. It takes 8-bit result bytes from core logic over a valid/ready handshake and shifts them out as asynchronous UART frames on one dedicated output pin. The frame format is 8N1 by default, LSB first. It is the transmit end of the tile's byte-serial link; the pin-facing receive path and the parallel datapath sit alongside it.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range 2..4096.
- `clk`  in  1  single clock; all state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a byte on `tx_data`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  frame in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- Handshake:
  - A transfer occurs on a rising edge where `tx_valid && tx_ready` is true.
  - `tx_ready` = 1 only in IDLE; it is registered, not combinational from `tx_valid`.
  - On transfer, `tx_data` is copied into an 8-bit shift register and the block enters START.
  - `tx_data` may change freely after the transfer edge.
- START: `tx` = 0 for `CLK_DIV` cycles.
- DATA: 8 bits, LSB first, each held for `CLK_DIV` cycles.
  - A 3-bit bit counter selects the bit; it wraps from 7 to 0 on the exit to the next state.
- PARITY: `tx` = even parity (XOR of the 8 latched bits) for `CLK_DIV` cycles.
- STOP: `tx` = 1 for `CLK_DIV` cycles, then IDLE.
- Baud counter: width `$clog2(CLK_DIV)`.
  - Counts 0..`CLK_DIV-1`, resets to 0 on every state change.
  - A bit boundary occurs when the count equals `CLK_DIV-1`.
- `tx` is driven from a flop (glitch-free); it is never a combinational decode of state.
- `tx_valid` asserted while `busy`: ignored; no data is lost because `tx_ready` is 0. The producer must hold the byte.
- `tx_valid` dropping before a transfer: no effect; the block stays in IDLE with `tx` = 1.

## Timing
- Reset values:
  - `tx` = 1, `tx_ready` = 1, `busy` = 0.
  - State = IDLE; baud and bit counters = 0; shift register = 0x00.
- Reset assertion mid-frame: `tx` returns to 1 asynchronously and the frame is abandoned. There is no partial-frame recovery.
- Latency:
  - The handshake edge is cycle 0.
  - `tx` falls to 0 and `busy` rises at cycle 1.
  - `tx_ready` falls at cycle 1.
- Frame length: 10×`CLK_DIV` cycles (11×`CLK_DIV` with parity), counted from the first START cycle.
- Return to idle:
  - `tx_ready` rises on the cycle after the last STOP cycle.
  - `busy` falls on that same cycle.
- Back-to-back: with `tx_valid` held high, exactly one IDLE cycle separates frames.
  - Sustained period = 10×`CLK_DIV` + 1 cycles (11×`CLK_DIV` + 1 with parity).
- Simultaneous events: the STOP-to-IDLE transition and a new `tx_valid` in the same cycle do not transfer. The transfer happens on the next edge, when `tx_ready` = 1.

## Configuration
- Macro: `MINIVAN_UART_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in.
  - Frames are 8E1: start, D0..D7, even-parity bit, stop; 11 bit times.
- Undefined:
  - The PARITY state and the parity XOR are absent.
  - Frames are 8N1; 10 bit times.
  - The state encoding has no unused PARITY code path.

## Test plan
- Reset: `rst_n` = 0 then released; `tx_valid` = 0 -> `tx` = 1, `tx_ready` = 1, `busy` = 0 held for 100 cycles.
- Single byte, `CLK_DIV` = 4, send 0xA5:
  - `tx` = 0 for cycles 1–4.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
  - Stop high for cycles 37–40.
  - `tx_ready` = 1 at cycle 41.
- Parity on, `CLK_DIV` = 4:
  - 0xA5 -> parity bit 0 (cycles 37–40).
  - 0x07 -> parity bit 1.
  - Stop occupies cycles 41–44.
- Back-to-back, `CLK_DIV` = 4, `tx_valid` held high with 0x00 then 0xFF:
  - The second start bit begins exactly 41 cycles after the first.
  - Decoded bytes match.
- Hold-off: pulse new `tx_data` = 0x3C with `tx_valid` during a frame, then keep it asserted -> no corruption of the current frame; 0x3C is sent next.
- Reset mid-frame: assert `rst_n` = 0 during DATA bit 3 -> `tx` = 1 immediately. After release, sending 0x5A produces a clean full frame.

Source files
------------

// File: rtl/minivan_uart_tx_if.sv
// Byte handshake between a producer and the minivan UART transmitter.
interface minivan_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/minivan_uart_tx.sv
// UART transmitter, 8N1 LSB-first; define MINIVAN_UART_PARITY_EN for 8E1 frames.
// tx and tx_ready come straight from flops; busy is any non-IDLE state.
module minivan_uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  minivan_uart_tx_if.slave    bus,
  output logic                tx,
  output logic                busy
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

`ifdef MINIVAN_UART_PARITY_EN
  localparam int SW = 3;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
`else
  localparam int SW = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
`endif

  logic [SW-1:0] state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          ready_q;
  logic          bit_end;

  assign bit_end      = (baud == BAUD_LAST);
  assign busy         = (state != ST_IDLE);
  assign bus.tx_ready = ready_q;

  // Baud counter idles at 0 and restarts on every bit boundary, which is
  // also every state change outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud <= '0;
    end else if (state == ST_IDLE || bit_end) begin
      baud <= '0;
    end else begin
      baud <= baud + BW'(1);
    end
  end

  // The latched byte stays intact for the whole frame; bit_cnt picks the bit
  // so the parity XOR can still see all eight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.tx_valid && ready_q) begin
            shreg   <= bus.tx_data;
            state   <= ST_START;
            tx      <= 1'b0;
            ready_q <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef MINIVAN_UART_PARITY_EN
              state <= ST_PARITY;
              tx    <= ^shreg;
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shreg[bit_cnt + 3'd1];
            end
          end
        end
`ifdef MINIVAN_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            tx      <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
